// File: rtl/uart_pkg.sv
// Frame constants, parity helper and FSM state encoding shared by the UART
// transmitter and receiver.
package uart_pkg;

  localparam int FRAME_BITS = 11;
  localparam int DATA_BITS  = 8;

  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;
  localparam logic IDLE_LEVEL  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    GAP
  } uart_state_e;

  // Even parity: the bit that makes the total count of ones even.
  function automatic logic calc_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO with first-word-fall-through read; full/empty come straight from
// the registered pointers.
module uart_tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [7:0]  r_mem [DEPTH];
  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign empty   = (r_wptr == r_rptr);
  assign rd_data = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (wr_en && !full)  r_wptr <= r_wptr + PTR_ONE;
      if (rd_en && !empty) r_rptr <= r_rptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !full) r_mem[r_wptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/uart_transmitter.sv
// FIFO-fed UART transmitter: start, 8 data bits LSB first, even parity, stop,
// then optional idle-high gap bits. tx is registered one cycle behind state.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1,
  parameter int DEPTH        = 4,
  parameter int GAP_BITS     = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       load,
  output logic       full,
  output logic       overflow,
  output logic       busy,
  output logic       tx
);

  localparam int DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  uart_state_e r_state, w_next_state;

  logic [DIV_W-1:0] r_div;
  logic [2:0]       r_bitcnt;
  logic [3:0]       r_gapcnt;
  logic [7:0]       r_shift;
  logic             r_parity;
  logic             r_tx;
  logic             r_busy;
  logic             r_overflow;

  logic       w_full;
  logic       w_empty;
  logic [7:0] w_fifo_data;
  logic       w_wr;
  logic       w_pop;
  logic       w_tick;
  logic       w_line;

  assign w_wr   = load && !w_full;
  assign w_tick = (r_div == DIV_W'(CLKS_PER_BIT - 1));

  uart_tx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (w_wr),
    .wr_data (data_in),
    .rd_en   (w_pop),
    .rd_data (w_fifo_data),
    .full    (w_full),
    .empty   (w_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  // The final idle-high bit of a frame (STOP, or GAP when gaps are enabled)
  // pops the next byte itself so consecutive frames need no IDLE cycle.
  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    w_line       = IDLE_LEVEL;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_next_state = START;
        end
      end
      START: begin
        w_line = START_LEVEL;
        if (w_tick) w_next_state = DATA;
      end
      DATA: begin
        w_line = r_shift[0];
        if (w_tick && r_bitcnt == 3'd7) w_next_state = PARITY;
      end
      PARITY: begin
        w_line = r_parity;
        if (w_tick) w_next_state = STOP;
      end
      STOP: begin
        w_line = STOP_LEVEL;
        if (w_tick) begin
          if (GAP_BITS > 0) begin
            w_next_state = GAP;
          end else if (!w_empty) begin
            w_pop        = 1'b1;
            w_next_state = START;
          end else begin
            w_next_state = IDLE;
          end
        end
      end
      GAP: begin
        w_line = IDLE_LEVEL;
        if (w_tick && r_gapcnt == 4'(GAP_BITS - 1)) begin
          if (!w_empty) begin
            w_pop        = 1'b1;
            w_next_state = START;
          end else begin
            w_next_state = IDLE;
          end
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_div      <= '0;
      r_bitcnt   <= '0;
      r_gapcnt   <= '0;
      r_shift    <= '0;
      r_parity   <= 1'b0;
      r_tx       <= IDLE_LEVEL;
      r_busy     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_tx       <= w_line;
      r_overflow <= load && w_full;
      r_busy     <= (r_state != IDLE) || !w_empty || w_wr;
      if (w_pop) begin
        r_shift  <= w_fifo_data;
        r_parity <= calc_parity(w_fifo_data);
        r_div    <= '0;
        r_bitcnt <= '0;
        r_gapcnt <= '0;
      end else if (r_state != IDLE) begin
        r_div <= w_tick ? '0 : r_div + DIV_W'(1);
        if (w_tick && r_state == DATA) begin
          r_shift  <= r_shift >> 1;
          r_bitcnt <= r_bitcnt + 3'd1;
        end
        if (w_tick && r_state == GAP) r_gapcnt <= r_gapcnt + 4'd1;
      end
    end
  end

  assign tx       = r_tx;
  assign busy     = r_busy;
  assign full     = w_full;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench: vector table, directed corner sequences and a random
// run decoded by a behavioural receiver model.
module tb_uart_transmitter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, load, full, ovf, busy, tx;
  logic [7:0] din;
  logic       rst2, load2, full2, ovf2, busy2, tx2;
  logic [7:0] din2;

  uart_transmitter #(.CLKS_PER_BIT(1), .DEPTH(4), .GAP_BITS(0)) dut (
    .clk(clk), .reset(rst), .data_in(din), .load(load),
    .full(full), .overflow(ovf), .busy(busy), .tx(tx));

  uart_transmitter #(.CLKS_PER_BIT(4), .DEPTH(4), .GAP_BITS(2)) dut2 (
    .clk(clk), .reset(rst2), .data_in(din2), .load(load2),
    .full(full2), .overflow(ovf2), .busy(busy2), .tx(tx2));

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Line order: index 0 is sent first.
  function automatic logic [10:0] ref_frame(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return {1'b1, 1'(ones % 2), d, 1'b0};
  endfunction

  // Per-cycle line recorders; index k is the tx value after the k-th edge.
  logic rq1[$];
  logic rq2[$];
  bit   rec1 = 0, rec2 = 0;
  always @(negedge clk) begin
    if (rec1) rq1.push_back(tx);
    if (rec2) rq2.push_back(tx2);
  end

  // Behavioural receiver for the random run.
  logic [7:0]  exp_q[$];
  logic [7:0]  got_q[$];
  bit          mon_en = 0, in_frame = 0;
  int          nb = 0, rx_err = 0, ovf_cnt = 0;
  logic [10:0] fr;
  always @(negedge clk) begin
    if (!mon_en) begin
      in_frame = 0;
    end else if (!in_frame) begin
      if (tx === 1'b0) begin in_frame = 1; nb = 1; fr = '0; end
    end else begin
      fr[nb] = tx;
      nb++;
      if (nb == 11) begin
        in_frame = 0;
        got_q.push_back(fr[8:1]);
        if (fr[10] !== 1'b1 || fr[9] !== ^fr[8:1]) rx_err++;
      end
    end
    if (mon_en && ovf) ovf_cnt++;
  end

  typedef struct {
    logic [7:0]  data;
    logic        exp_par;
    logic [10:0] exp_bits;
  } vec_t;
  vec_t vt[6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [10:0] got;
    int bad, guard, timeouts, sp;

    vt[0] = '{8'hA5, 1'b0, 11'b1_0_10100101_0};
    vt[1] = '{8'h07, 1'b1, 11'b1_1_00000111_0};
    vt[2] = '{8'h00, 1'b0, 11'b1_0_00000000_0};
    vt[3] = '{8'hFF, 1'b0, 11'b1_0_11111111_0};
    vt[4] = '{8'h80, 1'b1, 11'b1_1_10000000_0};
    vt[5] = '{8'h3C, 1'b0, 11'b1_0_00111100_0};

    rst = 1; load = 0; din = 8'h00;
    rst2 = 1; load2 = 0; din2 = 8'h00;
    tick(); tick();
    chk("reset_tx", tx, 1);
    chk("reset_busy", busy, 0);
    chk("reset_full", full, 0);
    chk("reset_ovf", ovf, 0);
    chk("reset_tx2", tx2, 1);
    chk("reset_busy2", busy2, 0);
    rst = 0; rst2 = 0;
    tick();

    // Single frames from the vector table
    for (int v = 0; v < 6; v++) begin
      load = 1; din = vt[v].data;
      tick();
      chk("busy_after_load", busy, 1);
      load = 0; din = 8'($urandom);
      tick();
      chk("idle_before_start", tx, 1);
      for (int i = 0; i < 11; i++) begin tick(); got[i] = tx; end
      chk($sformatf("frame_%02h", vt[v].data), got, vt[v].exp_bits);
      chk($sformatf("parity_%02h", vt[v].data), got[9], vt[v].exp_par);
      chk("busy_last_stop", busy, 1);
      tick();
      chk("busy_done", busy, 0);
      chk("tx_idle_after", tx, 1);
      repeat (2) tick();
    end

    // Burst of five into a depth-4 FIFO, then one load while full
    rq1.delete();
    for (int i = 0; i < 5; i++) begin
      load = 1; din = 8'h11 + 8'(i);
      tick();
      if (i == 0) rec1 = 1;
      chk("burst_no_ovf", ovf, 0);
      if (i == 3) chk("burst_not_full", full, 0);
      if (i == 4) chk("burst_full", full, 1);
    end
    din = 8'h99;
    tick();
    chk("ovf_pulse", ovf, 1);
    load = 0;
    tick();
    chk("ovf_one_cycle", ovf, 0);
    repeat (70) tick();
    rec1 = 0;
    for (int f = 0; f < 5; f++) begin
      for (int b = 0; b < 11; b++) got[b] = rq1[2 + 11*f + b];
      chk($sformatf("burst_frame%0d", f), got, ref_frame(8'h11 + 8'(f)));
    end
    bad = 0;
    for (int k = 57; k < rq1.size(); k++) if (rq1[k] !== 1'b1) bad++;
    chk("burst_idle_after", bad, 0);
    chk("burst_busy_end", busy, 0);

    // Slow bit rate with gap bits, two frames queued
    rq2.delete();
    load2 = 1; din2 = 8'h80;
    tick();
    rec2 = 1;
    din2 = 8'h55;
    tick();
    load2 = 0;
    repeat (110) tick();
    rec2 = 0;
    got = ref_frame(8'h80);
    bad = 0;
    for (int b = 0; b < 11; b++)
      for (int j = 0; j < 4; j++) if (rq2[2 + 4*b + j] !== got[b]) bad++;
    chk("gap_frame0", bad, 0);
    bad = 0;
    for (int k = 46; k < 54; k++) if (rq2[k] !== 1'b1) bad++;
    chk("gap_idle8", bad, 0);
    chk("gap_next_start", rq2[54], 0);
    got = ref_frame(8'h55);
    bad = 0;
    for (int b = 0; b < 11; b++)
      for (int j = 0; j < 4; j++) if (rq2[54 + 4*b + j] !== got[b]) bad++;
    chk("gap_frame1", bad, 0);
    chk("gap_busy_end", busy2, 0);

    // Reset in the middle of data bits with two bytes queued
    load = 1; din = 8'h3C; tick();
    din = 8'h01; tick();
    din = 8'h02; tick();
    load = 0;
    tick();
    tick();
    chk("pre_reset_bit1", tx, 0);
    tick(); tick();
    chk("pre_reset_bit3", tx, 1);
    rst = 1;
    tick();
    chk("reset_mid_tx", tx, 1);
    chk("reset_mid_busy", busy, 0);
    chk("reset_mid_full", full, 0);
    rst = 0;
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    chk("no_frames_after_reset", bad, 0);

    // Random bytes with random spacing through the receiver model
    mon_en = 1;
    timeouts = 0;
    for (int n = 0; n < 250; n++) begin
      sp = $urandom_range(0, 14);
      repeat (sp) tick();
      guard = 0;
      while ((exp_q.size() - got_q.size()) >= 4 && guard < 500) begin tick(); guard++; end
      if (guard >= 500) timeouts++;
      load = 1; din = 8'($urandom);
      exp_q.push_back(din);
      tick();
      load = 0; din = 8'($urandom);
    end
    guard = 0;
    while (got_q.size() < exp_q.size() && guard < 5000) begin tick(); guard++; end
    repeat (3) tick();
    chk("rand_drain_bound", guard < 5000, 1);
    chk("rand_wait_bound", timeouts, 0);
    chk("rand_count", got_q.size(), exp_q.size());
    bad = 0;
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
      if (got_q[k] !== exp_q[k]) bad++;
    chk("rand_order", bad, 0);
    chk("rand_rx_err", rx_err, 0);
    chk("rand_no_ovf", ovf_cnt, 0);
    chk("rand_busy_end", busy, 0);
    mon_en = 0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
